// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_pkg;

   typedef enum logic [0:0] {
      SHOW_TIME = 1'b0,
      SHOW_OVR  = 1'b1
   } scan_state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Width of a counter/index covering 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Override requester handshake: level request with nibble payload, grant and done pulse back.
interface seg_scan_ctrl_if #(
   parameter int DIGITS = 6
);
   logic                  ovr_req;
   logic [4*DIGITS-1:0]   ovr_data;
   logic                  ovr_gnt;
   logic                  ovr_done;

   modport master (
      output ovr_req,
      output ovr_data,
      input  ovr_gnt,
      input  ovr_done
   );

   modport slave (
      input  ovr_req,
      input  ovr_data,
      output ovr_gnt,
      output ovr_done
   );
endinterface

// File: rtl/seg_scan_timebase.sv
// Slot prescaler and digit index for the display scan; flags slot ticks and frame boundaries.
module seg_scan_timebase
   import seg_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter int SCAN_DIV = 1024
) (
   input  logic                          clock,
   input  logic                          reset,
   output logic [idx_width(DIGITS)-1:0]  index,
   output logic [idx_width(DIGITS)-1:0]  index_next,
   output logic                          slot_tick,
   output logic                          frame_boundary
);
   localparam int IW = idx_width(DIGITS);
   localparam int PW = idx_width(SCAN_DIV);
   localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [PW-1:0] prescaler_reg;
   logic [IW-1:0] index_reg;

   assign slot_tick      = (prescaler_reg == PS_LAST);
   assign frame_boundary = slot_tick && (index_reg == IDX_LAST);
   assign index          = index_reg;

   always_comb begin
      index_next = index_reg;
      if (slot_tick) begin
         index_next = (index_reg == IDX_LAST) ? '0 : index_reg + IW'(1);
      end
   end

   // Index resets to the last digit so the first slot tick opens a fresh frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prescaler_reg <= '0;
         index_reg     <= IDX_LAST;
      end else begin
         prescaler_reg <= slot_tick ? '0 : prescaler_reg + PW'(1);
         index_reg     <= index_next;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Display scan scheduler: arbitrates time vs. override ownership per frame and drives the
// registered nibble/select pair with blink and decimal-point masking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS       = 6,
   parameter int SCAN_DIV     = 1024,
   parameter int BLINK_FRAMES = 64,
   parameter int HOLD_FRAMES  = 128
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [4*DIGITS-1:0]           time_bcd,
   input  logic [DIGITS-1:0]             blink_mask,
   input  logic [DIGITS-1:0]             dp_mask,
   seg_scan_ctrl_if.slave                ovr,
   output logic [idx_width(DIGITS)-1:0]  digit_sel,
   output logic [3:0]                    digit_val,
   output logic                          blank,
   output logic                          dp,
   output logic                          frame_tick
);
   localparam int IW = idx_width(DIGITS);
   localparam int BW = idx_width(BLINK_FRAMES);
   localparam int HW = idx_width(HOLD_FRAMES);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

   logic [IW-1:0]       index, index_next;
   logic                slot_tick, frame_boundary;

   scan_state_e         state_reg, state_next;
   logic                armed_reg, armed_next;
   logic [4*DIGITS-1:0] time_shadow_reg, time_shadow_next;
   logic [4*DIGITS-1:0] ovr_shadow_reg, ovr_shadow_next;
   logic [BW-1:0]       blink_cnt_reg, blink_cnt_next;
   logic                blink_phase_reg, blink_phase_next;
   logic                frame_seen_reg, frame_seen_next;
   logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;
   logic                ovr_done_next;
   logic                ovr_gnt_reg, ovr_done_reg, frame_tick_reg;
   logic [3:0]          digit_val_reg, digit_val_next;
   logic                blank_reg, blank_next;
   logic                dp_reg, dp_next;

   logic [3:0]          time_nib [DIGITS];
   logic [3:0]          ovr_nib  [DIGITS];
   logic [3:0]          cur_time_nib, cur_ovr_nib;

   seg_scan_timebase #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_timebase (
      .clock          (clock),
      .reset          (reset),
      .index          (index),
      .index_next     (index_next),
      .slot_tick      (slot_tick),
      .frame_boundary (frame_boundary)
   );

   // Outputs are built from the post-edge shadows so the new digit lands with its new index.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign time_nib[gi] = time_shadow_next[4*gi +: 4];
      assign ovr_nib[gi]  = ovr_shadow_next[4*gi +: 4];
   end

   assign cur_time_nib = time_nib[index_next];
   assign cur_ovr_nib  = ovr_nib[index_next];

   always_comb begin
      state_next       = state_reg;
      armed_next       = armed_reg | ~ovr.ovr_req;
      time_shadow_next = time_shadow_reg;
      ovr_shadow_next  = ovr_shadow_reg;
      blink_cnt_next   = blink_cnt_reg;
      blink_phase_next = blink_phase_reg;
      frame_seen_next  = frame_seen_reg;
      hold_cnt_next    = hold_cnt_reg;
      ovr_done_next    = 1'b0;

      if (frame_boundary) begin
         time_shadow_next = time_bcd;
         frame_seen_next  = 1'b1;
         // The first boundary after reset closes a partial frame, so it is not counted.
         if (frame_seen_reg) begin
            if (blink_cnt_reg == BLINK_LAST) begin
               blink_cnt_next   = '0;
               blink_phase_next = ~blink_phase_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + BW'(1);
            end
         end

         case (state_reg)
            SHOW_TIME: begin
               if (ovr.ovr_req && armed_reg) begin
                  state_next      = SHOW_OVR;
                  ovr_shadow_next = ovr.ovr_data;
                  hold_cnt_next   = '0;
                  armed_next      = 1'b0;
               end
            end
            SHOW_OVR: begin
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_next    = SHOW_TIME;
                  ovr_done_next = 1'b1;
               end else begin
                  hold_cnt_next = hold_cnt_reg + HW'(1);
               end
            end
            default: state_next = SHOW_TIME;
         endcase
      end
   end

   always_comb begin
      digit_val_next = digit_val_reg;
      blank_next     = blank_reg;
      dp_next        = dp_reg;
      if (slot_tick) begin
         if (state_next == SHOW_OVR) begin
            digit_val_next = cur_ovr_nib;
            blank_next     = 1'b0;
         end else if (cur_time_nib > BCD_MAX) begin
            digit_val_next = 4'd0;
            blank_next     = 1'b1;
         end else begin
            digit_val_next = cur_time_nib;
            blank_next     = blink_phase_next & blink_mask[index_next];
         end
         dp_next = dp_mask[index_next] & ~blank_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= SHOW_TIME;
         armed_reg       <= 1'b1;
         time_shadow_reg <= '0;
         ovr_shadow_reg  <= '0;
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
         frame_seen_reg  <= 1'b0;
         hold_cnt_reg    <= '0;
         ovr_gnt_reg     <= 1'b0;
         ovr_done_reg    <= 1'b0;
         frame_tick_reg  <= 1'b0;
         digit_val_reg   <= 4'd0;
         blank_reg       <= 1'b1;
         dp_reg          <= 1'b0;
      end else begin
         state_reg       <= state_next;
         armed_reg       <= armed_next;
         time_shadow_reg <= time_shadow_next;
         ovr_shadow_reg  <= ovr_shadow_next;
         blink_cnt_reg   <= blink_cnt_next;
         blink_phase_reg <= blink_phase_next;
         frame_seen_reg  <= frame_seen_next;
         hold_cnt_reg    <= hold_cnt_next;
         ovr_gnt_reg     <= (state_next == SHOW_OVR);
         ovr_done_reg    <= ovr_done_next;
         frame_tick_reg  <= frame_boundary;
         digit_val_reg   <= digit_val_next;
         blank_reg       <= blank_next;
         dp_reg          <= dp_next;
      end
   end

   assign digit_sel    = index;
   assign digit_val    = digit_val_reg;
   assign blank        = blank_reg;
   assign dp           = dp_reg;
   assign frame_tick   = frame_tick_reg;
   assign ovr.ovr_gnt  = ovr_gnt_reg;
   assign ovr.ovr_done = ovr_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-level reference model.
module tb_seg_scan_ctrl;
   localparam int DIGITS       = 6;
   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int HOLD_FRAMES  = 3;
   localparam int FRAME        = DIGITS * SCAN_DIV;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] time_bcd = '0;
   logic [5:0]  blink_mask = '0;
   logic [5:0]  dp_mask = '0;
   logic        ovr_req = 1'b0;
   logic [23:0] ovr_data = '0;
   logic [2:0]  digit_sel;
   logic [3:0]  digit_val;
   logic        blank, dp, frame_tick, ovr_gnt, ovr_done;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   seg_scan_ctrl_if #(.DIGITS(DIGITS)) ovr_if ();
   assign ovr_if.ovr_req  = ovr_req;
   assign ovr_if.ovr_data = ovr_data;
   assign ovr_gnt  = ovr_if.ovr_gnt;
   assign ovr_done = ovr_if.ovr_done;

   seg_scan_ctrl #(
      .DIGITS       (DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES),
      .HOLD_FRAMES  (HOLD_FRAMES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .time_bcd   (time_bcd),
      .blink_mask (blink_mask),
      .dp_mask    (dp_mask),
      .ovr        (ovr_if),
      .digit_sel  (digit_sel),
      .digit_val  (digit_val),
      .blank      (blank),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   // Reference model: cycle count since release -> slot number -> frame number; ownership
   // decided per frame from request history.
   int          m_cyc = 0, m_slot = 0, m_idx = 0, m_frame = 0, m_gframe = 0;
   bit          m_ovr = 1'b0, m_armed = 1'b1;
   logic [23:0] m_time = '0, m_ovr_data = '0;
   logic [3:0]  m_nib;
   logic [2:0]  exp_sel = 3'd5;
   logic [3:0]  exp_val = 4'd0;
   logic        exp_blank = 1'b1, exp_dp = 1'b0, exp_ftick = 1'b0, exp_gnt = 1'b0, exp_done = 1'b0;
   logic [11:0] obs, exp_vec;

   assign obs     = {digit_sel, digit_val, blank, dp, frame_tick, ovr_gnt, ovr_done};
   assign exp_vec = {exp_sel, exp_val, exp_blank, exp_dp, exp_ftick, exp_gnt, exp_done};

   initial begin
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            m_cyc = 0; m_frame = 0; m_ovr = 1'b0; m_armed = 1'b1;
            exp_sel = 3'd5; exp_val = 4'd0; exp_blank = 1'b1; exp_dp = 1'b0;
            exp_ftick = 1'b0; exp_gnt = 1'b0; exp_done = 1'b0;
         end else begin
            m_cyc++;
            exp_ftick = 1'b0;
            exp_done  = 1'b0;
            if (m_cyc % SCAN_DIV == 0) begin
               m_slot = m_cyc / SCAN_DIV;
               m_idx  = (m_slot - 1) % DIGITS;
               if (m_idx == 0) begin
                  m_frame   = (m_slot - 1) / DIGITS + 1;
                  exp_ftick = 1'b1;
                  m_time    = time_bcd;
                  if (m_ovr) begin
                     if (m_frame - m_gframe == HOLD_FRAMES) begin
                        m_ovr    = 1'b0;
                        exp_done = 1'b1;
                     end
                  end else if (ovr_req && m_armed) begin
                     m_ovr = 1'b1; m_gframe = m_frame; m_ovr_data = ovr_data; m_armed = 1'b0;
                  end
               end
               exp_sel = 3'(m_idx);
               m_nib   = 4'(((m_ovr ? m_ovr_data : m_time) >> (4 * m_idx)) & 24'hF);
               if (m_ovr) begin
                  exp_val = m_nib; exp_blank = 1'b0;
               end else if (m_nib > 4'd9) begin
                  exp_val = 4'd0; exp_blank = 1'b1;
               end else begin
                  exp_val   = m_nib;
                  exp_blank = (((m_frame - 1) / BLINK_FRAMES) % 2 == 1) && blink_mask[m_idx];
               end
               exp_dp = dp_mask[m_idx] && !exp_blank;
            end
            if (!ovr_req) m_armed = 1'b1;
            exp_gnt = m_ovr;
         end
      end
   end

   function automatic logic [23:0] rand_bcd();
      logic [23:0] v;
      for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   task automatic test_reset();
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (digit_sel !== 3'd5) begin errors++; $display("FAIL reset_sel got=%0d exp=5", digit_sel); end
      checks++; if (digit_val !== 4'd0) begin errors++; $display("FAIL reset_val got=%0d exp=0", digit_val); end
      checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", blank); end
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp got=%b exp=0", dp); end
      checks++; if (ovr_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", ovr_gnt); end
      checks++; if (ovr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", ovr_done); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ftick got=%b exp=0", frame_tick); end
   endtask

   task automatic test_scan();
      int k;
      time_bcd = 24'h123456; blink_mask = '0; dp_mask = '0; ovr_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int c = 1; c <= 2 * FRAME + 4; c++) begin
         @(negedge clock);
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL scan cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
         if (c <= FRAME && c % SCAN_DIV == 0) begin
            k = c / SCAN_DIV - 1;
            checks++;
            if (digit_sel !== 3'(k) || digit_val !== 4'(6 - k) || blank !== 1'b0 || frame_tick !== (k == 0)) begin
               errors++;
               $display("FAIL scan_seq cyc=%0d got sel=%0d val=%0d blank=%b ftick=%b exp sel=%0d val=%0d blank=0 ftick=%b",
                        c, digit_sel, digit_val, blank, frame_tick, k, 6 - k, k == 0);
            end
         end
      end
   endtask

   task automatic test_tear();
      logic [23:0] old_bcd, new_bcd;
      int n;
      dp_mask = 6'($urandom);
      repeat (4) begin
         n = 0;
         while (digit_sel !== 3'd2 && n < 2 * FRAME) begin @(negedge clock); n++; end
         old_bcd  = time_bcd;
         new_bcd  = rand_bcd();
         time_bcd = new_bcd;
         n = 0;
         while (n < 2 * FRAME) begin
            @(negedge clock); n++;
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL tear_model got=%h exp=%h", obs, exp_vec); end
            if (frame_tick === 1'b1) break;
            checks++;
            if (digit_val !== 4'((old_bcd >> (4 * digit_sel)) & 24'hF)) begin
               errors++; $display("FAIL tear_old sel=%0d got=%0d exp=%0d", digit_sel, digit_val, (old_bcd >> (4 * digit_sel)) & 24'hF);
            end
         end
         checks++;
         if (frame_tick !== 1'b1 || digit_val !== new_bcd[3:0]) begin
            errors++; $display("FAIL tear_new ftick=%b got=%0d exp=%0d", frame_tick, digit_val, new_bcd[3:0]);
         end
      end
   endtask

   task automatic test_blink();
      int fcount = 0;
      logic exp_b;
      @(negedge clock); reset = 1'b0;
      time_bcd = 24'h12A456; blink_mask = 6'b000011; dp_mask = 6'($urandom);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int c = 1; c <= 7 * FRAME + 4; c++) begin
         @(negedge clock);
         if (frame_tick === 1'b1) fcount++;
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL blink_model cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
         if (fcount >= 1 && fcount <= 6) begin
            exp_b = (digit_sel == 3'd3) || (digit_sel < 3'd2 && (fcount == 3 || fcount == 4));
            checks++;
            if (blank !== exp_b) begin
               errors++; $display("FAIL blink frame=%0d sel=%0d got=%b exp=%b", fcount, digit_sel, blank, exp_b);
            end
         end
      end
   endtask

   task automatic test_override();
      int n = 0, gnt_cycles = 0, done_count = 0;
      blink_mask = '0; time_bcd = rand_bcd();
      while (digit_sel !== 3'd2 && n < 2 * FRAME) begin @(negedge clock); n++; end
      ovr_data = 24'hABCDEF; ovr_req = 1'b1;
      for (int c = 0; c < 5 * FRAME; c++) begin
         @(negedge clock);
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL ovr_model cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
         if (ovr_done === 1'b1) done_count++;
         if (ovr_gnt === 1'b1) begin
            gnt_cycles++;
            checks++;
            if (digit_val !== 4'(15 - digit_sel) || blank !== 1'b0) begin
               errors++; $display("FAIL ovr_digit sel=%0d got val=%0d blank=%b exp val=%0d blank=0",
                                  digit_sel, digit_val, blank, 15 - digit_sel);
            end
            ovr_req  = 1'b0;
            ovr_data = 24'($urandom);
         end
      end
      checks++; if (done_count != 1) begin errors++; $display("FAIL ovr_done_count got=%0d exp=1", done_count); end
      checks++;
      if (gnt_cycles != HOLD_FRAMES * FRAME) begin
         errors++; $display("FAIL ovr_hold_cycles got=%0d exp=%0d", gnt_cycles, HOLD_FRAMES * FRAME);
      end
   endtask

   task automatic test_fairness();
      int n = 0;
      ovr_req = 1'b1; ovr_data = 24'($urandom);
      while (ovr_gnt !== 1'b1 && n < 2 * FRAME) begin @(negedge clock); n++; end
      checks++; if (ovr_gnt !== 1'b1) begin errors++; $display("FAIL fair_grant1 got=%b exp=1", ovr_gnt); end
      n = 0;
      while (ovr_gnt !== 1'b0 && n < 5 * FRAME) begin @(negedge clock); n++; end
      checks++; if (ovr_gnt !== 1'b0) begin errors++; $display("FAIL fair_expire got=%b exp=0", ovr_gnt); end
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clock);
         checks++;
         if (ovr_gnt !== 1'b0 || obs !== exp_vec) begin
            errors++; $display("FAIL fair_no_regrant cyc=%0d got=%h exp=%h", c, obs, exp_vec);
         end
      end
      ovr_req = 1'b0;
      @(negedge clock);
      ovr_req = 1'b1;
      n = 0;
      while (ovr_gnt !== 1'b1 && n < FRAME + SCAN_DIV) begin @(negedge clock); n++; end
      checks++;
      if (ovr_gnt !== 1'b1 || frame_tick !== 1'b1) begin
         errors++; $display("FAIL fair_regrant got gnt=%b ftick=%b exp gnt=1 ftick=1", ovr_gnt, frame_tick);
      end
      ovr_req = 1'b0;
      n = 0;
      while (ovr_gnt !== 1'b0 && n < 5 * FRAME) begin @(negedge clock); n++; end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      ovr_req = 1'b1; ovr_data = 24'($urandom);
      while (ovr_gnt !== 1'b1 && n < 2 * FRAME) begin @(negedge clock); n++; end
      checks++; if (ovr_gnt !== 1'b1) begin errors++; $display("FAIL rmid_grant got=%b exp=1", ovr_gnt); end
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ovr_gnt !== 1'b0 || blank !== 1'b1 || digit_sel !== 3'd5 || ovr_done !== 1'b0) begin
         errors++; $display("FAIL rmid_async got gnt=%b blank=%b sel=%0d done=%b exp gnt=0 blank=1 sel=5 done=0",
                            ovr_gnt, blank, digit_sel, ovr_done);
      end
      ovr_req = 1'b0;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (ovr_done !== 1'b0 || ovr_gnt !== 1'b0) begin
            errors++; $display("FAIL rmid_hold got done=%b gnt=%b exp 0 0", ovr_done, ovr_gnt);
         end
      end
      reset = 1'b1;
      for (int c = 1; c <= FRAME + 8; c++) begin
         @(negedge clock);
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL rmid_model cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
         if (c < SCAN_DIV) begin
            checks++;
            if (digit_sel !== 3'd5) begin errors++; $display("FAIL rmid_restart cyc=%0d got=%0d exp=5", c, digit_sel); end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
         if ($urandom_range(0, 19) == 0) ovr_req = ~ovr_req;
         if ($urandom_range(0, 29) == 0) time_bcd = ($urandom_range(0, 1) == 0) ? rand_bcd() : 24'($urandom);
         if ($urandom_range(0, 49) == 0) blink_mask = 6'($urandom);
         if ($urandom_range(0, 49) == 0) dp_mask = 6'($urandom);
         ovr_data = 24'($urandom);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tear();
      test_blink();
      test_override();
      test_fairness();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
